// File: rtl/mips_instr_issuer_if.sv
// Loader/control and CPU-facing instruction signals of the instruction issuer.
interface mips_instr_issuer_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic [31:0]       instrword;
  logic              newinstr;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [15:0]       instr_count;

  // Loader / testbench side.
  modport master (
    output load_en, load_addr, load_data, start,
    input  instrword, newinstr, pc, busy, done, instr_count
  );

  // Issuer side.
  modport slave (
    input  load_en, load_addr, load_data, start,
    output instrword, newinstr, pc, busy, done, instr_count
  );
endinterface

// File: rtl/mips_instr_issuer.sv
// Sequential instruction issuer: presents each imem word to the CPU for a fixed
// execution window, stopping at the halt word or at the last memory address.
module mips_instr_issuer #(
  parameter int unsigned IMEM_DEPTH  = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned EXEC_CYCLES = 4,
  parameter logic [31:0] HALT_WORD   = 32'hFC000000
) (
  input logic               clock,
  input logic               rst,
  mips_instr_issuer_if.slave bus
);

  localparam int unsigned CntW = $clog2(EXEC_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StExec, StDone} state_t;

  state_t            state_q, state_d;
  logic [31:0]       imem [IMEM_DEPTH];
  logic [31:0]       rd_word;
  logic [31:0]       instrword_q;
  logic              newinstr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       count_q;
  logic [CntW-1:0]   cnt_q;

  logic is_halt, last_addr, cnt_zero;
  logic busy, done, restart, issue_fire, write_en;

  assign rd_word   = imem[pc_q];
  assign is_halt   = (rd_word == HALT_WORD);
  assign last_addr = (pc_q == ADDR_W'(IMEM_DEPTH - 1));
  assign cnt_zero  = (cnt_q == '0);

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus.start) state_d = StIssue;
      StIssue:        state_d = is_halt ? StDone : StExec;
      StExec:         if (cnt_zero) state_d = last_addr ? StDone : StIssue;
      default:        state_d = StIdle;
    endcase
  end

  // Status outputs and datapath strobes decoded from the current state.
  always_comb begin
    busy       = (state_q == StIssue) || (state_q == StExec);
    done       = (state_q == StDone);
    // Loads and starts are only honoured while not running.
    restart    = !busy && bus.start;
    write_en   = !busy && bus.load_en;
    issue_fire = (state_q == StIssue) && !is_halt;
  end

  // Instruction memory write port; contents intentionally survive reset.
  always_ff @(posedge clock) begin
    if (write_en) imem[bus.load_addr] <= bus.load_data;
  end

  // Datapath registers: PC, issued word, new-instruction pulse, counters.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      instrword_q <= '0;
      newinstr_q  <= 1'b0;
      pc_q        <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
    end else begin
      newinstr_q <= 1'b0;
      if (restart) begin
        pc_q    <= '0;
        count_q <= '0;
      end
      if (issue_fire) begin
        instrword_q <= rd_word;
        newinstr_q  <= 1'b1;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        cnt_q <= CntW'(EXEC_CYCLES - 1);
      end
      if (state_q == StExec) begin
        if (!cnt_zero)      cnt_q <= cnt_q - CntW'(1);
        // No wrap-around: the last address stays put and the run ends.
        else if (!last_addr) pc_q <= pc_q + ADDR_W'(1);
      end
    end
  end

  assign bus.instrword   = instrword_q;
  assign bus.newinstr    = newinstr_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.instr_count = count_q;

endmodule
